alu_core: RTL
=============

Name: alu_core

Overview:
- Registered ALU DUT: the responder side of the ALU stimulus/response interface.
- Accepts operands, command and mode under clock enable, and produces res plus status flags (cout, oflow, err, g, l, e) one clock edge later.
- Supports split operand delivery: if only one operand is valid, the block waits a bounded number of cycles for the other.
- Sits directly under the interface in the ALU verification environment, and is the block the reference model is checked against.

Parameters:
- WIDTH, 8, operand width; res is WIDTH+1 bits.
- CMD_WIDTH, 4, command field width.
- TIMEOUT, 16, maximum cycles spent in WAIT for a missing operand.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  clock enable; 0 freezes all state and outputs.
- mode  input  1  1 = arithmetic, 0 = logical.
- cmd  input  CMD_WIDTH  operation select.
- inp_valid  input  2  bit0 = opa valid, bit1 = opb valid.
- opa, opb  input  WIDTH  operands.
- cin  input  1  carry/borrow-in for the *_CIN commands.
- res  output  WIDTH+1  result.
- cout  output  1  carry out.
- oflow  output  1  borrow / underflow.
- err  output  1  illegal cmd, rotate-amount error, or operand timeout.
- g, l, e  output  1 each  compare results for opa vs opb.

Behaviour:
- Reset (asynchronous, any time, including mid-WAIT):
  - All outputs go to 0.
  - FSM returns to IDLE; wait counter and latched operand/cmd/mode/cin are cleared.
- ce=0: no state change; all outputs hold their last value.
- Arithmetic commands (mode=1), all computed at WIDTH+1 bits:
  - 0 ADD: res=opa+opb.
  - 1 SUB: res=opa-opb; oflow=(opa<opb).
  - 2 ADD_CIN: res=opa+opb+cin.
  - 3 SUB_CIN: res=opa-opb-cin; oflow=(opa<opb+cin).
  - 4 INC_A, 5 DEC_A: need opa only.
  - 6 INC_B, 7 DEC_B: need opb only.
  - 8 CMP: res=0; exactly one of g, l, e is set.
  - For all arithmetic results, cout=res[WIDTH].
- Logical commands (mode=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 8 SHR1_A, 9 SHL1_A: need opa only.
  - 7 NOT_B, 10 SHR1_B, 11 SHL1_B: need opb only.
  - 12 ROL_A_B, 13 ROR_A_B: rotate opa by opb[$clog2(WIDTH)-1:0]. err=1 and res=0 if any higher opb bit is set.
  - All logical results have res[WIDTH]=0.
- Unused cmd codes: err=1, res=0, other flags 0.
- Every computation writes all outputs. Flags not defined by the command are 0, so no stale flags remain.
- Latency: result and flags are registered at the first ce edge on which all required operands are present.
- FSM states: IDLE and WAIT.
  - IDLE, inp_valid==00: outputs hold; no operation.
  - IDLE, required operands present: compute; stay in IDLE.
  - IDLE, only the non-required operand or half of a two-operand pair present: latch cmd, mode, cin and the supplied operand; count=1; go to WAIT.
  - WAIT, ce=1: cmd, mode and cin inputs are ignored and the latched values are used. If inp_valid supplies the missing operand, compute from latched + new operand and go to IDLE. If the latched operand is re-presented, it is overwritten.
  - WAIT, count==TIMEOUT without the missing operand: err=1, res=0, go to IDLE.
  - WAIT, ce=0: counter does not advance.
- A single-operand command with the wrong operand valid (e.g. INC_A with inp_valid=10) enters WAIT for opa.

Decomposition:
- Package alu_pkg holds:
  - WIDTH, CMD_WIDTH and TIMEOUT defaults.
  - enums arith_cmd_e and logic_cmd_e.
  - state enum alu_state_e {IDLE, WAIT}.
  - function needs_operands(mode, cmd) returning 2'b01, 2'b10 or 2'b11.
- One sub-module, alu_compute: purely combinational datapath mapping (mode, cmd, opa, opb, cin) to next res and flags.
- alu_core owns the FSM, operand latches, wait counter and output registers.

Test Plan:
- rst asserted mid-WAIT between clock edges -> all outputs 0 immediately; next ADD 1+1 with inp_valid=11 gives res=2.
- mode=1, ADD, opa=200, opb=100, inp_valid=11 -> next edge res=9'h12C, cout=1, err=0.
- SUB opa=5, opb=10 -> res=9'h1FB, oflow=1. CMP opa=7, opb=7 -> e=1, g=0, l=0, res=0.
- ADD with inp_valid=01, opa=3; 4 cycles later inp_valid=10, opb=4 -> res=7 on that edge. Repeat with opb never supplied -> err=1 exactly on the 16th edge, res=0.
- mode=0, ROL_A_B, opa=8'h81, opb=1 -> res=9'h003. Same with opb=8'h10 -> err=1, res=0.
- ce=0 for 3 cycles while inputs change -> res and flags unchanged. cmd=15, mode=1 -> err=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: shared widths, command encodings and operand-need decoder   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH     = 8;
  localparam int ALU_CMD_WIDTH = 4;
  localparam int ALU_TIMEOUT   = 16;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } alu_state_e;

  // bit0 = opa required, bit1 = opb required; illegal codes ask for both
  function automatic logic [1:0] needs_operands(input logic mode, input logic [3:0] cmd);
    logic [1:0] need;
    need = 2'b11;
    if (mode) begin
      case (cmd)
        A_INC_A, A_DEC_A: need = 2'b01;
        A_INC_B, A_DEC_B: need = 2'b10;
        default:          need = 2'b11;
      endcase
    end else begin
      case (cmd)
        L_NOT_A, L_SHR1_A, L_SHL1_A: need = 2'b01;
        L_NOT_B, L_SHR1_B, L_SHL1_B: need = 2'b10;
        default:                     need = 2'b11;
      endcase
    end
    return need;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_compute.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_compute: combinational ALU datapath producing result and flags   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_compute
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int CMD_WIDTH = ALU_CMD_WIDTH
) (
  input  logic                 mode_i,
  input  logic [CMD_WIDTH-1:0] cmd_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic                 cin_i,
  output logic [WIDTH:0]       res_o,
  output logic                 cout_o,
  output logic                 oflow_o,
  output logic                 err_o,
  output logic                 g_o,
  output logic                 l_o,
  output logic                 e_o
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] C_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_c;
  logic [3:0]       w_code;
  logic             w_hi_ok;
  logic [SHW-1:0]   w_amt;
  logic             w_amt_err;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  assign w_a       = {1'b0, opa_i};
  assign w_b       = {1'b0, opb_i};
  assign w_c       = {{WIDTH{1'b0}}, cin_i};
  assign w_code    = cmd_i[3:0];
  assign w_hi_ok   = (cmd_i >> 4) == '0;
  assign w_amt     = opb_i[SHW-1:0];
  assign w_amt_err = (opb_i >> SHW) != '0;
  assign w_rol     = (opa_i << w_amt) | (opa_i >> (WIDTH - int'(w_amt)));
  assign w_ror     = (opa_i >> w_amt) | (opa_i << (WIDTH - int'(w_amt)));

  always_comb begin
    res_o   = '0;
    cout_o  = 1'b0;
    oflow_o = 1'b0;
    err_o   = 1'b0;
    g_o     = 1'b0;
    l_o     = 1'b0;
    e_o     = 1'b0;
    if (!w_hi_ok) begin
      err_o = 1'b1;
    end else if (mode_i) begin
      case (w_code)
        A_ADD:     res_o = w_a + w_b;
        A_SUB: begin
          res_o   = w_a - w_b;
          oflow_o = w_a < w_b;
        end
        A_ADD_CIN: res_o = w_a + w_b + w_c;
        A_SUB_CIN: begin
          res_o   = w_a - w_b - w_c;
          oflow_o = w_a < (w_b + w_c);
        end
        A_INC_A:   res_o = w_a + C_ONE;
        A_DEC_A:   res_o = w_a - C_ONE;
        A_INC_B:   res_o = w_b + C_ONE;
        A_DEC_B:   res_o = w_b - C_ONE;
        A_CMP: begin
          g_o = opa_i > opb_i;
          l_o = opa_i < opb_i;
          e_o = opa_i == opb_i;
        end
        default:   err_o = 1'b1;
      endcase
      cout_o = res_o[WIDTH];
    end else begin
      case (w_code)
        L_AND:     res_o = {1'b0, opa_i & opb_i};
        L_NAND:    res_o = {1'b0, ~(opa_i & opb_i)};
        L_OR:      res_o = {1'b0, opa_i | opb_i};
        L_NOR:     res_o = {1'b0, ~(opa_i | opb_i)};
        L_XOR:     res_o = {1'b0, opa_i ^ opb_i};
        L_XNOR:    res_o = {1'b0, ~(opa_i ^ opb_i)};
        L_NOT_A:   res_o = {1'b0, ~opa_i};
        L_NOT_B:   res_o = {1'b0, ~opb_i};
        L_SHR1_A:  res_o = {1'b0, opa_i >> 1};
        L_SHL1_A:  res_o = {1'b0, opa_i << 1};
        L_SHR1_B:  res_o = {1'b0, opb_i >> 1};
        L_SHL1_B:  res_o = {1'b0, opb_i << 1};
        L_ROL_A_B: if (w_amt_err) err_o = 1'b1; else res_o = {1'b0, w_rol};
        L_ROR_A_B: if (w_amt_err) err_o = 1'b1; else res_o = {1'b0, w_ror};
        default:   err_o = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_core: registered ALU with split-operand wait FSM and timeout     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int CMD_WIDTH = ALU_CMD_WIDTH,
  parameter int TIMEOUT   = ALU_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 mode,
  input  logic [CMD_WIDTH-1:0] cmd,
  input  logic [1:0]           inp_valid,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  input  logic                 cin,
  output logic [WIDTH:0]       res,
  output logic                 cout,
  output logic                 oflow,
  output logic                 err,
  output logic                 g,
  output logic                 l,
  output logic                 e
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  alu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mode_q, mode_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic                 cin_q, cin_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [1:0]           have_q, have_d;
  logic [WIDTH:0]       res_q, res_d;
  logic                 cout_q, cout_d;
  logic                 oflow_q, oflow_d;
  logic                 err_q, err_d;
  logic                 g_q, g_d;
  logic                 l_q, l_d;
  logic                 e_q, e_d;

  logic                 w_mode;
  logic [CMD_WIDTH-1:0] w_cmd;
  logic                 w_cin;
  logic [WIDTH-1:0]     w_opa;
  logic [WIDTH-1:0]     w_opb;
  logic [1:0]           w_need;
  logic [1:0]           w_have;
  logic                 w_ready;
  logic [WIDTH:0]       w_res;
  logic                 w_cout, w_oflow, w_err, w_g, w_l, w_e;

  // In WAIT the latched command context replaces the live inputs
  assign w_mode  = (state_q == WAIT) ? mode_q : mode;
  assign w_cmd   = (state_q == WAIT) ? cmd_q  : cmd;
  assign w_cin   = (state_q == WAIT) ? cin_q  : cin;
  assign w_opa   = inp_valid[0] ? opa : opa_q;
  assign w_opb   = inp_valid[1] ? opb : opb_q;
  assign w_need  = needs_operands(w_mode, w_cmd[3:0]);
  assign w_have  = ((state_q == WAIT) ? have_q : 2'b00) | inp_valid;
  assign w_ready = (w_have & w_need) == w_need;

  alu_compute #(
    .WIDTH     (WIDTH),
    .CMD_WIDTH (CMD_WIDTH)
  ) u_compute (
    .mode_i  (w_mode),
    .cmd_i   (w_cmd),
    .opa_i   (w_opa),
    .opb_i   (w_opb),
    .cin_i   (w_cin),
    .res_o   (w_res),
    .cout_o  (w_cout),
    .oflow_o (w_oflow),
    .err_o   (w_err),
    .g_o     (w_g),
    .l_o     (w_l),
    .e_o     (w_e)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    cin_d   = cin_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    have_d  = have_q;
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    err_d   = err_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    if (ce) begin
      if ((state_q == IDLE && inp_valid != 2'b00 && w_ready) ||
          (state_q == WAIT && w_ready)) begin
        res_d   = w_res;
        cout_d  = w_cout;
        oflow_d = w_oflow;
        err_d   = w_err;
        g_d     = w_g;
        l_d     = w_l;
        e_d     = w_e;
        state_d = IDLE;
        count_d = '0;
        have_d  = 2'b00;
      end else if (state_q == IDLE && inp_valid != 2'b00) begin
        mode_d  = mode;
        cmd_d   = cmd;
        cin_d   = cin;
        opa_d   = w_opa;
        opb_d   = w_opb;
        have_d  = inp_valid;
        count_d = CNT_W'(1);
        state_d = WAIT;
      end else if (state_q == WAIT && count_q == CNT_W'(TIMEOUT)) begin
        res_d   = '0;
        cout_d  = 1'b0;
        oflow_d = 1'b0;
        err_d   = 1'b1;
        g_d     = 1'b0;
        l_d     = 1'b0;
        e_d     = 1'b0;
        state_d = IDLE;
        count_d = '0;
        have_d  = 2'b00;
      end else if (state_q == WAIT) begin
        count_d = count_q + CNT_W'(1);
        opa_d   = w_opa;
        opb_d   = w_opb;
        have_d  = w_have;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      cin_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      have_q  <= 2'b00;
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      err_q   <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      cin_q   <= cin_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      have_q  <= have_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      err_q   <= err_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
    end
  end

  assign res   = res_q;
  assign cout  = cout_q;
  assign oflow = oflow_q;
  assign err   = err_q;
  assign g     = g_q;
  assign l     = l_q;
  assign e     = e_q;

endmodule
`default_nettype wire
